// File: rtl/hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard unit.
// Used by the forwarding selectors and the hazard sequencer.
package cpu_hazard_pkg;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_t;

   localparam logic [2:0] FWD_RD = 3'b000;
   localparam logic [2:0] FWD_W  = 3'b001;
   localparam logic [2:0] FWD_M  = 3'b010;

   localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

   // x0 is hardwired to zero, so a write to it never produces a forwardable value.
   function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
      return we && (rd != 5'd0) && (rd == rs);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
// The master drives register/control observations and consumes stall, flush and forward selects.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       Rs1E;
   logic [4:0]       Rs2E;
   logic [4:0]       RdE;
   logic [4:0]       RdM;
   logic [4:0]       RdW;
   logic             RegWriteM;
   logic             RegWriteW;
   logic [1:0]       ResultSrcE;
   logic             PCSrcE;
   logic             MemReqM;
   logic             MemReadyM;
   logic [2:0]       ForwardAE;
   logic [2:0]       ForwardBE;
   logic             StallF;
   logic             StallD;
   logic             StallE;
   logic             FlushD;
   logic             FlushE;
   logic [CNT_W-1:0] StallCnt;
   logic             MemTimeout;

   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
      input  StallCnt, MemTimeout
   );

   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
      output StallCnt, MemTimeout
   );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding priority for one Execute-stage source register.
// The younger M-stage result shadows the older W-stage result.
module fwd_sel
   import cpu_hazard_pkg::*;
(
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [2:0] sel
);

   always_comb begin
      sel = FWD_RD;
      if (reg_hit(reg_write_m, rd_m, rs)) begin
         sel = FWD_M;
      end else if (reg_hit(reg_write_w, rd_w, rs)) begin
         sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer: operand forwarding, load-use stall, branch flush and a
// whole-pipe freeze while a data-memory access waits, plus stall/timeout monitors.
module hazard_ctrl
   import cpu_hazard_pkg::*;
#(
   parameter int          CNT_W   = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   hazard_ctrl_if.slave   hz
);

   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   hz_state_t        state_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;
   logic              mem_timeout_reg;

   logic       freeze;
   logic       lw_stall;
   logic       stall_f;
   logic       stall_d;
   logic       stall_e;
   logic       flush_d;
   logic       flush_e;
   logic [4:0] rs_e  [2];
   logic [2:0] fwd_w [2];

   assign rs_e[0] = hz.Rs1E;
   assign rs_e[1] = hz.Rs2E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_sel u_fwd_sel (
            .rs          (rs_e[gi]),
            .rd_m        (hz.RdM),
            .rd_w        (hz.RdW),
            .reg_write_m (hz.RegWriteM),
            .reg_write_w (hz.RegWriteW),
            .sel         (fwd_w[gi])
         );
      end
   endgenerate

   // A miss freezes the pipe in the very cycle it is seen, before the FSM has moved.
   assign freeze = !hz.MemReadyM &&
                   ((state_reg == RUN && hz.MemReqM) || (state_reg == MEM_WAIT));

   assign lw_stall = (hz.ResultSrcE == RESULTSRC_LOAD) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (rst) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (freeze) begin
         // E is held, so a pending branch flush is simply deferred to the release cycle.
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
      end else if (hz.PCSrcE) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (lw_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= RUN;
         wait_cnt_reg    <= '0;
         stall_cnt_reg   <= '0;
         mem_timeout_reg <= 1'b0;
      end else begin
         if (stall_f && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end
         case (state_reg)
            RUN: begin
               if (hz.MemReqM && !hz.MemReadyM) begin
                  state_reg    <= MEM_WAIT;
                  wait_cnt_reg <= '0;
               end
            end
            MEM_WAIT: begin
               if (hz.MemReadyM) begin
                  state_reg <= RUN;
               end
               // Counter parks at TIMEOUT; the flag is sticky so one hit is enough.
               if (32'(wait_cnt_reg) < TIMEOUT) begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
               if ((TIMEOUT != 0) && (32'(wait_cnt_reg) + 32'd1 == TIMEOUT)) begin
                  mem_timeout_reg <= 1'b1;
               end
            end
            default: state_reg <= RUN;
         endcase
      end
   end

   assign hz.ForwardAE  = rst ? FWD_RD : fwd_w[0];
   assign hz.ForwardBE  = rst ? FWD_RD : fwd_w[1];
   assign hz.StallF     = stall_f;
   assign hz.StallD     = stall_d;
   assign hz.StallE     = stall_e;
   assign hz.FlushD     = flush_d;
   assign hz.FlushE     = flush_e;
   assign hz.StallCnt   = stall_cnt_reg;
   assign hz.MemTimeout = mem_timeout_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, memory freeze,
// watchdog (separate instance with a short timeout) and reset during a wait.
module tb_hazard_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(32)) hif ();
   hazard_ctrl_if #(.CNT_W(32)) tif ();

   hazard_ctrl #(.CNT_W(32), .TIMEOUT(255)) dut (
      .clk (clk),
      .rst (rst),
      .hz  (hif)
   );

   hazard_ctrl #(.CNT_W(32), .TIMEOUT(3)) dut_t (
      .clk (clk),
      .rst (rst),
      .hz  (tif)
   );

   task automatic clear_inputs();
      hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
      hif.RdE = 5'd0; hif.RdM = 5'd0; hif.RdW = 5'd0;
      hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.ResultSrcE = 2'b00;
      hif.PCSrcE = 1'b0; hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
      tif.Rs1D = 5'd0; tif.Rs2D = 5'd0; tif.Rs1E = 5'd0; tif.Rs2E = 5'd0;
      tif.RdE = 5'd0; tif.RdM = 5'd0; tif.RdW = 5'd0;
      tif.RegWriteM = 1'b0; tif.RegWriteW = 1'b0; tif.ResultSrcE = 2'b00;
      tif.PCSrcE = 1'b0; tif.MemReqM = 1'b0; tif.MemReadyM = 1'b0;
   endtask

   // Advance to 1ns after the next rising edge; inputs are driven here, outputs checked at +3.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1;
      hif.MemReqM = 1'b1;
      rst = 1'b1;
      #3;
      total_cnt++; if (hif.StallF !== 1'b0) $display("FAIL rst_stallf: got %b want 0", hif.StallF); else pass_cnt++;
      total_cnt++; if (hif.StallE !== 1'b0) $display("FAIL rst_stalle: got %b want 0", hif.StallE); else pass_cnt++;
      total_cnt++; if ({hif.FlushD, hif.FlushE} !== 2'b11) $display("FAIL rst_flush: got %b want 11", {hif.FlushD, hif.FlushE}); else pass_cnt++;
      total_cnt++; if (hif.ForwardAE !== 3'b000) $display("FAIL rst_fwda: got %b want 000", hif.ForwardAE); else pass_cnt++;
      step();
      total_cnt++; if (hif.StallCnt !== 32'd0) $display("FAIL rst_stallcnt: got %0d want 0", hif.StallCnt); else pass_cnt++;
      total_cnt++; if (tif.MemTimeout !== 1'b0) $display("FAIL rst_timeout: got %b want 0", tif.MemTimeout); else pass_cnt++;
      rst = 1'b0;
      clear_inputs();
      step();
      $display("reset: outputs checked during and after rst");
   endtask

   task automatic test_forwarding();
      clear_inputs();
      hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1; hif.RdW = 5'd5; hif.RegWriteW = 1'b1;
      #3;
      total_cnt++; if (hif.ForwardAE !== 3'b010) $display("FAIL fwd_m_prio: got %b want 010", hif.ForwardAE); else pass_cnt++;
      step();
      hif.RdM = 5'd0;
      #3;
      total_cnt++; if (hif.ForwardAE !== 3'b001) $display("FAIL fwd_w: got %b want 001", hif.ForwardAE); else pass_cnt++;
      step();
      hif.RdM = 5'd5; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
      hif.Rs2E = 5'd9; hif.RdW = 5'd9; hif.RegWriteW = 1'b1;
      #3;
      total_cnt++; if (hif.ForwardAE !== 3'b000) $display("FAIL fwd_nowrite: got %b want 000", hif.ForwardAE); else pass_cnt++;
      total_cnt++; if (hif.ForwardBE !== 3'b001) $display("FAIL fwd_b_w: got %b want 001", hif.ForwardBE); else pass_cnt++;
      step();
      clear_inputs();
      hif.RegWriteM = 1'b1; hif.RegWriteW = 1'b1;
      #3;
      total_cnt++; if ({hif.ForwardAE, hif.ForwardBE} !== 6'b000000) $display("FAIL fwd_x0: got %b want 000000", {hif.ForwardAE, hif.ForwardBE}); else pass_cnt++;
      step();
      clear_inputs();
      $display("forwarding: M/W priority, operand B and x0 cases applied");
   endtask

   task automatic test_load_use();
      do_reset();
      clear_inputs();
      hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
      #3;
      total_cnt++; if ({hif.StallF, hif.StallD, hif.FlushE} !== 3'b111) $display("FAIL lu_stall: got %b want 111", {hif.StallF, hif.StallD, hif.FlushE}); else pass_cnt++;
      total_cnt++; if ({hif.StallE, hif.FlushD} !== 2'b00) $display("FAIL lu_other: got %b want 00", {hif.StallE, hif.FlushD}); else pass_cnt++;
      step();
      clear_inputs();
      #3;
      total_cnt++; if ({hif.StallF, hif.StallD, hif.FlushE} !== 3'b000) $display("FAIL lu_clear: got %b want 000", {hif.StallF, hif.StallD, hif.FlushE}); else pass_cnt++;
      total_cnt++; if (hif.StallCnt !== 32'd1) $display("FAIL lu_cnt: got %0d want 1", hif.StallCnt); else pass_cnt++;
      step();
      hif.ResultSrcE = 2'b01; hif.RdE = 5'd0; hif.Rs1D = 5'd0;
      #3;
      total_cnt++; if (hif.StallF !== 1'b0) $display("FAIL lu_x0: got %b want 0", hif.StallF); else pass_cnt++;
      step();
      clear_inputs();
      $display("load_use: one-cycle stall on Rs2D match");
   endtask

   task automatic test_branch();
      clear_inputs();
      hif.PCSrcE = 1'b1; hif.Rs1E = 5'd5; hif.RdM = 5'd5; hif.RegWriteM = 1'b1;
      #3;
      total_cnt++; if ({hif.FlushD, hif.FlushE, hif.StallF} !== 3'b110) $display("FAIL br_flush: got %b want 110", {hif.FlushD, hif.FlushE, hif.StallF}); else pass_cnt++;
      total_cnt++; if (hif.ForwardAE !== 3'b010) $display("FAIL br_fwd: got %b want 010", hif.ForwardAE); else pass_cnt++;
      step();
      hif.ResultSrcE = 2'b01; hif.RdE = 5'd3; hif.Rs1D = 5'd3;
      #3;
      total_cnt++; if ({hif.FlushD, hif.FlushE, hif.StallF, hif.StallD} !== 4'b1100) $display("FAIL br_over_lu: got %b want 1100", {hif.FlushD, hif.FlushE, hif.StallF, hif.StallD}); else pass_cnt++;
      step();
      clear_inputs();
      $display("branch: flush, forwarding intact, flush beats load-use");
   endtask

   task automatic test_mem_freeze();
      do_reset();
      clear_inputs();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0; hif.PCSrcE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #3;
         total_cnt++;
         if ({hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE} !== 5'b11100)
            $display("FAIL freeze_c%0d: got %b want 11100", i, {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE});
         else pass_cnt++;
         step();
      end
      hif.MemReadyM = 1'b1;
      #3;
      total_cnt++; if ({hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE} !== 5'b00011) $display("FAIL freeze_release: got %b want 00011", {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE}); else pass_cnt++;
      step();
      hif.PCSrcE = 1'b0;
      #3;
      total_cnt++; if (hif.StallCnt !== 32'd4) $display("FAIL freeze_cnt: got %0d want 4", hif.StallCnt); else pass_cnt++;
      total_cnt++; if (hif.StallF !== 1'b0) $display("FAIL zero_wait: got %b want 0", hif.StallF); else pass_cnt++;
      step();
      hif.MemReqM = 1'b0; hif.MemReadyM = 1'b0;
      #3;
      total_cnt++; if (hif.StallF !== 1'b0) $display("FAIL after_zero_wait: got %b want 0", hif.StallF); else pass_cnt++;
      total_cnt++; if (hif.StallCnt !== 32'd4) $display("FAIL zero_wait_cnt: got %0d want 4", hif.StallCnt); else pass_cnt++;
      step();
      clear_inputs();
      $display("mem_freeze: 4 frozen cycles, deferred branch flush on release");
   endtask

   task automatic test_timeout();
      do_reset();
      clear_inputs();
      tif.MemReqM = 1'b1; tif.MemReadyM = 1'b0;
      step();
      for (int i = 1; i <= 3; i++) begin
         #3;
         total_cnt++; if (tif.MemTimeout !== 1'b0) $display("FAIL to_early_w%0d: got %b want 0", i, tif.MemTimeout); else pass_cnt++;
         step();
      end
      #3;
      total_cnt++; if (tif.MemTimeout !== 1'b1) $display("FAIL to_set: got %b want 1", tif.MemTimeout); else pass_cnt++;
      total_cnt++; if (tif.StallF !== 1'b1) $display("FAIL to_still_wait: got %b want 1", tif.StallF); else pass_cnt++;
      step();
      tif.MemReadyM = 1'b1;
      step();
      tif.MemReqM = 1'b0; tif.MemReadyM = 1'b0;
      step();
      #3;
      total_cnt++; if (tif.MemTimeout !== 1'b1) $display("FAIL to_sticky: got %b want 1", tif.MemTimeout); else pass_cnt++;
      total_cnt++; if (tif.StallF !== 1'b0) $display("FAIL to_released: got %b want 0", tif.StallF); else pass_cnt++;
      do_reset();
      #3;
      total_cnt++; if (tif.MemTimeout !== 1'b0) $display("FAIL to_cleared: got %b want 0", tif.MemTimeout); else pass_cnt++;
      clear_inputs();
      $display("timeout: flag after 3rd wait cycle, sticky until rst");
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      clear_inputs();
      hif.MemReqM = 1'b1; hif.MemReadyM = 1'b0;
      step();
      step();
      #1;
      total_cnt++; if (hif.StallF !== 1'b1) $display("FAIL mid_waiting: got %b want 1", hif.StallF); else pass_cnt++;
      rst = 1'b1;
      #1;
      total_cnt++; if ({hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE} !== 5'b00011) $display("FAIL mid_rst_out: got %b want 00011", {hif.StallF, hif.StallD, hif.StallE, hif.FlushD, hif.FlushE}); else pass_cnt++;
      step();
      rst = 1'b0;
      hif.MemReqM = 1'b0;
      #3;
      total_cnt++; if (hif.StallF !== 1'b0) $display("FAIL mid_state_run: got %b want 0", hif.StallF); else pass_cnt++;
      total_cnt++; if (hif.StallCnt !== 32'd0) $display("FAIL mid_cnt: got %0d want 0", hif.StallCnt); else pass_cnt++;
      step();
      clear_inputs();
      $display("reset_mid_wait: freeze released, counters cleared");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch();
      test_mem_freeze();
      test_timeout();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
